// File: rtl/psum_row_acc.sv
// psum_row_acc: accumulates K-pass psum vectors into a row buffer, then streams rows to sfp
module psum_row_acc #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int rows    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [4:0]               k_len,
    input  logic                     ofifo_valid,
    input  logic [col*bw_psum-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    input  logic                     out_ready,
    output logic [col*bw_psum-1:0]   sfp_in,
    output logic                     norm,
    output logic                     busy,
    output logic                     done
);
    localparam int rw = $clog2(rows);
    localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2, DONE = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [rw-1:0]          r_cnt_q, r_cnt_d;
    logic [4:0]             k_cnt_q, k_cnt_d, k_eff_q, k_eff_d;
    logic [col*bw_psum-1:0] sfp_in_q, sfp_in_d, acc_row;
    logic                   norm_q, norm_d, done_q, done_d;
    logic [col*bw_psum-1:0] row_buf_q [rows];
    logic                   last_row;

    assign ofifo_rd = state_q == ACC && ofifo_valid && !reset;
    assign busy     = state_q == ACC || state_q == OUT;
    assign sfp_in   = sfp_in_q;
    assign norm     = norm_q;
    assign done     = done_q;
    assign last_row = r_cnt_q == rw'(rows-1);

    // pass 0 overwrites the row; later passes add with plain wrapping two's-complement
    always_comb begin
        acc_row = '0;
        for (int c = 0; c < col; c++)
            acc_row[c*bw_psum +: bw_psum] = (k_cnt_q == 5'd0) ? ofifo_out[c*bw_psum +: bw_psum]
                : row_buf_q[r_cnt_q][c*bw_psum +: bw_psum] + ofifo_out[c*bw_psum +: bw_psum];
    end

    // tile sequencing: row counter wraps naturally since rows is a power of two
    always_comb begin
        state_d  = state_q;
        r_cnt_d  = r_cnt_q;
        k_cnt_d  = k_cnt_q;
        k_eff_d  = k_eff_q;
        sfp_in_d = sfp_in_q;
        norm_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                k_eff_d = (k_len == 5'd0) ? 5'd1 : k_len;
                r_cnt_d = '0;
                k_cnt_d = '0;
                state_d = ACC;
            end
            ACC: if (ofifo_rd) begin
                r_cnt_d = r_cnt_q + 1'b1;
                if (last_row) begin
                    k_cnt_d = k_cnt_q + 5'd1;
                    if (k_cnt_q == k_eff_q - 5'd1) state_d = OUT;
                end
            end
            OUT: if (out_ready) begin
                sfp_in_d = row_buf_q[r_cnt_q];
                norm_d   = 1'b1;
                r_cnt_d  = r_cnt_q + 1'b1;
                if (last_row) state_d = DONE;
            end
            default: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            r_cnt_q  <= '0;
            k_cnt_q  <= '0;
            k_eff_q  <= '0;
            sfp_in_q <= '0;
            norm_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_cnt_q  <= r_cnt_d;
            k_cnt_q  <= k_cnt_d;
            k_eff_q  <= k_eff_d;
            sfp_in_q <= sfp_in_d;
            norm_q   <= norm_d;
            done_q   <= done_d;
        end
    end

    // row buffer has no reset; pass 0 of every tile rewrites each row
    always_ff @(posedge clk) begin
        if (ofifo_rd) row_buf_q[r_cnt_q] <= acc_row;
    end
endmodule

// File: tb/tb_psum_row_acc.sv
// tb_psum_row_acc: randomized tiles checked against a summing reference model
module tb_psum_row_acc;
    localparam int COL = 8, BWP = 20, ROWS = 8;
    typedef logic [COL*BWP-1:0] vec_t;

    logic clk = 1'b0, reset, start, ofifo_valid, ofifo_rd, out_ready, norm, busy, done;
    logic [4:0] k_len;
    vec_t ofifo_out, sfp_in;
    int errors = 0, checks = 0;

    psum_row_acc dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
        .out_ready(out_ready), .sfp_in(sfp_in), .norm(norm), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // mode 0 random, 1 lane=n-3, 2 alternating 250/-100 plus lane index, 3 max positive
    function automatic vec_t make_vec(input int mode, input int n);
        vec_t v = '0;
        int k = n / ROWS;
        for (int c = 0; c < COL; c++) begin
            int x;
            x = mode == 1 ? n - 3 : mode == 2 ? (((k % 2) != 0) ? -100 : 250) + c
              : mode == 3 ? 32'h7FFFF : int'($urandom);
            v[c*BWP +: BWP] = BWP'(x);
        end
        return v;
    endfunction

    // vmode: 0 valid always, 1 valid one cycle in three, 2 random valid and ready
    task automatic run_tile(input logic [4:0] kl, input int mode, input int vmode, input bit stall, input bit poke);
        int keff = (kl == 5'd0) ? 1 : int'(kl);
        vec_t vecs[$];
        vec_t exp_rows[ROWS];
        vec_t last = '0;
        int n = 0, cyc = 0, got = 0, issued = 0;
        bit prev_x = 0, fin = 0;
        for (int i = 0; i < ROWS*keff; i++) vecs.push_back(make_vec(mode, i));
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COL; c++) begin
                int s = 0;
                for (int k = 0; k < keff; k++) s += int'($signed(vecs[k*ROWS+r][c*BWP +: BWP]));
                exp_rows[r][c*BWP +: BWP] = BWP'(s);
            end
        start = 1'b1; k_len = kl; ofifo_valid = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0; k_len = 5'($urandom);
        while (n < ROWS*keff && cyc < 2000) begin
            ofifo_valid = vmode == 0 ? 1'b1 : vmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            ofifo_out = ofifo_valid ? vecs[n] : rand_vec();
            start = poke && cyc == 2;
            @(negedge clk);
            check("acc_busy", busy, 1);
            check("acc_rd", ofifo_rd, ofifo_valid);
            check("acc_norm", norm, 0);
            if (ofifo_valid) n++;
            step();
            cyc++;
        end
        check("acc_len", n, ROWS*keff);
        cyc = 0;
        while (cyc < 300) begin
            out_ready = (stall && cyc >= 3 && cyc < 8) ? 1'b0 : vmode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
            ofifo_valid = 1'b1; ofifo_out = rand_vec(); start = poke && cyc == 1;
            @(negedge clk);
            check("out_rd", ofifo_rd, 0);
            check("out_busy", busy, issued < ROWS);
            check("out_norm", norm, prev_x);
            check("done", done, fin);
            if (fin) break;
            if (norm) begin
                check($sformatf("row%0d", got), sfp_in, exp_rows[got % ROWS]);
                last = sfp_in;
                got++;
            end else if (got > 0) check("hold", sfp_in, last);
            prev_x = out_ready && issued < ROWS;
            issued += int'(prev_x);
            fin = norm && got == ROWS;
            step();
            cyc++;
        end
        check("out_finish", fin, 1);
        start = 1'b0; ofifo_valid = 1'b0;
        step();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; k_len = 5'd1; ofifo_valid = 1'b1; ofifo_out = '0; out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_rd", ofifo_rd, 0);
        step();
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
        @(negedge clk);
        check("rst_sfp", sfp_in, 0);
        check("rst_norm", norm, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step();
        run_tile(5'd1, 1, 0, 0, 0);
        check("single_lane7", sfp_in[7*BWP +: BWP], 20'd4);
        run_tile(5'd4, 2, 0, 0, 0);
        check("multi_lane7", sfp_in[7*BWP +: BWP], 20'd328);
        run_tile(5'd2, 3, 0, 0, 0);
        check("wrap_lane0", sfp_in[BWP-1:0], 20'hFFFFE);
        run_tile(5'd3, 0, 1, 1, 0);
        run_tile(5'd0, 1, 0, 0, 0);
        check("k0_lane0", sfp_in[BWP-1:0], 20'd4);
        run_tile(5'd2, 0, 0, 0, 1);
        // abandon a tile in its third ACC cycle; start during reset must be ignored
        start = 1'b1; k_len = 5'd2; step();
        start = 1'b0; ofifo_valid = 1'b1; ofifo_out = rand_vec();
        step(); step();
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        check("mid_rst_rd", ofifo_rd, 0);
        step();
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("mid_rst_sfp", sfp_in, 0);
        check("mid_rst_norm", norm, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd2", ofifo_rd, 0);
        step();
        ofifo_valid = 1'b0;
        run_tile(5'd1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) run_tile(5'($urandom_range(0, 4)), 0, 2, i % 2 == 0, i % 3 == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psum_row_acc.md
# psum_row_acc

Accumulates signed partial-sum vectors from the MAC array output FIFO over a programmable number of K-passes into a rows×col register buffer. It then streams each accumulated row, one per `norm` pulse, into the `sfp` normalization stage as `sfp_in`. It sits directly upstream of `sfp` in each core. A ready input lets the core controller hold the stream until the peer core's sum exchange is available.

## Interface
- `col`, 8, vector lanes per row (matches `sfp`)
- `bw`, 8, operand width
- `bw_psum`, 2*bw+4 = 20, per-lane psum width, two's complement
- `rows`, 8, rows held in the buffer (power of two)
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse, begins a new tile; honoured only in IDLE
- `k_len`  in  5  number of K-passes per tile; sampled on accepted `start`; 0 treated as 1
- `ofifo_valid`  in  1  upstream FIFO holds a vector
- `ofifo_out`  in  col*bw_psum  upstream vector, lane c at bits [bw_psum*(c+1)-1 : bw_psum*c]
- `ofifo_rd`  out  1  pop strobe, combinational
- `out_ready`  in  1  downstream may accept a row this cycle
- `sfp_in`  out  col*bw_psum  accumulated row, same lane packing; registered
- `norm`  out  1  `sfp_in` valid this cycle; registered
- `busy`  out  1  high in ACC and OUT
- `done`  out  1  one-cycle pulse after the last row is emitted

## Operation
- States: IDLE, ACC, OUT, DONE.
- **IDLE**
  - `start` latches `k_eff = (k_len==0) ? 1 : k_len` and clears `r_cnt` and `k_cnt`; next state ACC.
- **ACC**
  - `ofifo_rd = ofifo_valid` (combinational); the data is consumed in the same cycle.
  - Arrival order: k-outer, row-inner. Vector n goes to row `r = n mod rows` at pass `k = n / rows`.
  - On each pop, per lane: `buf[r][c] <= (k_cnt==0) ? ofifo_out_c : buf[r][c] + ofifo_out_c`.
  - Addition is signed, truncated to bw_psum bits, and wraps with no saturation.
  - `r_cnt` increments and wraps at rows-1; `k_cnt` increments on each wrap.
  - The pop with `r_cnt==rows-1` and `k_cnt==k_eff-1` transitions to OUT with `r_cnt` cleared.
  - When `ofifo_valid` is low, counters hold and the buffer is unchanged.
- **OUT**
  - Each cycle with `out_ready=1`: `sfp_in <= buf[r_cnt]`, `norm <= 1`, `r_cnt++`.
  - When `out_ready=0`: `norm <= 0`, `sfp_in` holds its last value.
  - The transfer of row rows-1 moves the FSM to DONE.
  - `ofifo_rd` is 0 in OUT.
- **DONE**
  - `done <= 1` for one cycle, `norm <= 0`; next state IDLE.
- `start` outside IDLE is ignored; `k_len` is not resampled.
- The buffer is never explicitly cleared; pass 0 overwrites every row.

## Timing
- Reset values: state IDLE, `r_cnt`=0, `k_cnt`=0, `sfp_in`=0, `norm`=0, `busy`=0, `done`=0. Buffer contents are don't-care.
- `ofifo_rd` is 0 during reset and in every state other than ACC.
- `start` at edge t puts the FSM in ACC at t+1. The first possible pop is cycle t+1.
- With `ofifo_valid` continuously high, ACC lasts exactly `rows*k_eff` cycles.
- `norm` and `sfp_in` appear one cycle after the `out_ready` cycle that transfers them. With `out_ready` held high, the rows `norm` pulses are back-to-back.
- `done` is asserted the cycle after the last `norm`.
- `busy` is combinational from state: it is 1 from the cycle after `start` through the last OUT cycle, and 0 in DONE.
- Reset asserted mid-tile (ACC or OUT) returns everything to reset values on the next edge. A partially accumulated tile is abandoned and `done` is never raised.
- A `start` in the same cycle as `reset` is ignored.

## Test plan
- **Single pass.** rows=8, `k_len`=1, vector n has every lane = n−3, `out_ready`=1.
  - Required: eight `norm` pulses with row r lanes = r−3 (rows 0..2 negative: −3, −2, −1).
  - Required: `done` one cycle after the 8th pulse.
- **Multi-pass signed accumulation.** `k_len`=4; pass k supplies lane c = (k%2 ? −100 : 250)+c.
  - Required: every row lane c = 300+4c.
- **Wrap.** `k_len`=2; every lane in both passes = 0x7FFFF (2^19−1).
  - Required: every lane = 0xFFFFE (−2 as a 20-bit value); no saturation.
- **Backpressure on both sides.**
  - Toggle `ofifo_valid` with a 1-in-3 pattern; ACC length equals the number of valid cycles (rows*`k_eff`), with no pops while valid is low.
  - Hold `out_ready`=0 for 5 cycles mid-OUT; `norm` stays 0 and `sfp_in` holds during the stall, with no skipped or repeated rows.
- **Control corners.**
  - `k_len`=0 behaves exactly as `k_len`=1.
  - `start` pulsed during ACC and during OUT has no effect on row count or data.
  - `reset` in the 3rd ACC cycle gives outputs = 0 and state IDLE next cycle.
  - A following `start` with `k_len`=1 produces a clean tile matching the single-pass case.
